// File: rtl/alu_iter.sv
// Registered 6502-style ALU with BCD add/sub and N-bit iterative shifts; 1 cycle latency, n+1 for SHLN/SHRN.
// One request in flight; results are held in DONE until out_ready, and in_ready is low while busy.
module alu_iter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic               decimal,
  input  logic               carry_in,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_out,
  output logic               carry_out,
  output logic               overflow_out,
  output logic               zero_out,
  output logic               negative_out
);

  localparam int NIB = WIDTH / 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_SHLN = 4'd9;
  localparam logic [3:0] OP_SHRN = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               flags_ok;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     bsum;
  logic [WIDTH:0]     dec;

  // Nibble-serial decimal correction; carry ripples from the low digit upward.
  function automatic logic [WIDTH:0] bcd_calc(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             cin,
                                              input logic             sub);
    logic [WIDTH-1:0] r;
    logic             c;
    logic [4:0]       t;
    r = '0;
    c = cin;
    for (int i = 0; i < NIB; i++) begin
      if (sub) begin
        t = {1'b0, a[4*i +: 4]} + {1'b0, ~b[4*i +: 4]} + {4'b0000, c};
        c = t[4];
        if (!t[4]) t = t - 5'd6;
      end else begin
        t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
        if (t > 5'd9) begin
          t = t + 5'd6;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
      end
      r[4*i +: 4] = t[3:0];
    end
    return {c, r};
  endfunction

  assign b_eff = (op == OP_SUB) ? ~input_b : input_b;
  assign bsum  = {1'b0, input_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
  assign dec   = bcd_calc(input_a, input_b, carry_in, op == OP_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    flags_ok = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          res_d   = input_a;
          c_d     = carry_in;
          v_d     = 1'b0;
          case (op)
            OP_ADD, OP_SUB: begin
              res_d = decimal ? dec[WIDTH-1:0] : bsum[WIDTH-1:0];
              c_d   = decimal ? dec[WIDTH] : bsum[WIDTH];
              // V always reflects the uncorrected binary sum, even in decimal mode.
              v_d   = (input_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (bsum[WIDTH-1] != input_a[WIDTH-1]);
            end
            OP_AND: res_d = input_a & input_b;
            OP_OR:  res_d = input_a | input_b;
            OP_XOR: res_d = input_a ^ input_b;
            OP_SHL: begin
              res_d = {input_a[WIDTH-2:0], 1'b0};
              c_d   = input_a[WIDTH-1];
            end
            OP_SHR: begin
              res_d = {1'b0, input_a[WIDTH-1:1]};
              c_d   = input_a[0];
            end
            OP_ROL: begin
              res_d = {input_a[WIDTH-2:0], carry_in};
              c_d   = input_a[WIDTH-1];
            end
            OP_ROR: begin
              res_d = {carry_in, input_a[WIDTH-1:1]};
              c_d   = input_a[0];
            end
            OP_SHLN, OP_SHRN: begin
              cnt_d = input_b[SHAMT_W-1:0];
              dir_d = (op == OP_SHRN);
              if (input_b[SHAMT_W-1:0] != '0) state_d = S_SHIFT;
            end
            default: begin
              flags_ok = 1'b0;
              c_d      = 1'b0;
            end
          endcase
          z_d = flags_ok && (res_d == '0);
          n_d = flags_ok && res_d[WIDTH-1];
        end
      end
      S_SHIFT: begin
        if (dir_q) begin
          res_d = {1'b0, res_q[WIDTH-1:1]};
          c_d   = res_q[0];
        end else begin
          res_d = {res_q[WIDTH-2:0], 1'b0};
          c_d   = res_q[WIDTH-1];
        end
        cnt_d = cnt_q - 1'b1;
        z_d   = (res_d == '0);
        n_d   = res_d[WIDTH-1];
        if (cnt_q == 1) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == S_IDLE);
    out_valid    = (state_q == S_DONE);
    alu_out      = res_q;
    carry_out    = c_q;
    overflow_out = v_q;
    zero_out     = z_q;
    negative_out = n_q;
  end

endmodule
